ifetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction controller.
- Owns the fetch PC and the instruction-memory request handshake.
- Holds a one-entry prefetch buffer (IR_buf) and the instruction register (I); presents W_IR_valid to the controller.
- Consumes the controller's write_pc, write_ir and pc_s to advance, load or redirect the stream.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_target.sv | 34 +++
 rtl/ifetch_unit.sv | 176 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared fetch-stage definitions: redirect source encodings, fetch FSM states
// and the default reset PC.
package ifetch_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'b00,
        WAIT = 2'b01,
        FULL = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/ifetch_target.sv
// Redirect target computation (branch or register source) with word alignment
// and a misalignment indication; purely combinational.
module ifetch_target
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        pc_s_i,
    input  logic [ADDR_W-1:0] pc_ir_i,
    input  logic [23:0]       imm24_i,
    input  logic [ADDR_W-1:0] reg_target_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              misalign_o
);

    logic signed [ADDR_W-1:0] br_off;
    logic        [ADDR_W-1:0] raw_target;

    // Word offset: sign-extended imm24 scaled by 4 (assumes ADDR_W > 26).
    assign br_off = ADDR_W'($signed({imm24_i, 2'b00}));

    always_comb begin
        raw_target = pc_ir_i;
        case (pc_s_i)
            PC_BR:   raw_target = pc_ir_i + ADDR_W'(4) + br_off;
            PC_REG:  raw_target = reg_target_i;
            default: raw_target = pc_ir_i;
        endcase
    end

    assign misalign_o = (raw_target[1:0] != 2'b00);
    assign target_o   = {raw_target[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem handshake, one-entry
// prefetch buffer and instruction register. Optional macro: IFETCH_ALIGN_CHK_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_pc,
    input  logic              write_ir,
    input  logic [1:0]        pc_s,
    input  logic [23:0]       imm24,
    input  logic [ADDR_W-1:0] reg_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       I,
    output logic [31:0]       IR_buf,
    output logic              W_IR_valid,
    output logic [ADDR_W-1:0] pc_ir,
    output logic              misalign_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic [ADDR_W-1:0] pc_ir_q, pc_ir_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [31:0]       i_q, i_d;
    logic [31:0]       ir_buf_q, ir_buf_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;
    logic              pend_q, pend_d;

    logic [ADDR_W-1:0] tgt;
    logic              tgt_misalign;
    logic              redirect;

    ifetch_target #(.ADDR_W(ADDR_W)) u_target (
        .pc_s_i       (pc_s),
        .pc_ir_i      (pc_ir_q),
        .imm24_i      (imm24),
        .reg_target_i (reg_target),
        .target_o     (tgt),
        .misalign_o   (tgt_misalign)
    );

    assign redirect  = write_pc && ((pc_s == PC_BR) || (pc_s == PC_REG));
    assign imem_req  = (state_q == REQ) && !rst;
    assign imem_addr = {fetch_pc_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        buf_pc_d      = buf_pc_q;
        pc_ir_d       = pc_ir_q;
        pend_pc_d     = pend_pc_q;
        i_d           = i_q;
        ir_buf_d      = ir_buf_q;
        valid_d       = valid_q;
        drop_d        = drop_q;
        pend_d        = pend_q;

        case (state_q)
            REQ: begin
                if (imem_ready) begin
                    inflight_pc_d = imem_addr;
                    fetch_pc_d    = pend_q ? pend_pc_q : fetch_pc_q + ADDR_W'(4);
                    pend_d        = 1'b0;
                    state_d       = WAIT;
                end
                // A presented request cannot be withdrawn: complete it, drop its
                // data, and park the target until the handshake finishes.
                if (redirect) begin
                    drop_d = 1'b1;
                    if (imem_ready) begin
                        fetch_pc_d = tgt;
                    end else begin
                        pend_d    = 1'b1;
                        pend_pc_d = tgt;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                    if (!drop_q && !redirect) begin
                        ir_buf_d = imem_rdata;
                        buf_pc_d = inflight_pc_q;
                        valid_d  = 1'b1;
                        state_d  = FULL;
                    end
                end
                if (redirect) begin
                    fetch_pc_d = tgt;
                    if (!imem_rvalid) drop_d = 1'b1;
                end
            end
            FULL: begin
                if (redirect) begin
                    valid_d    = 1'b0;
                    fetch_pc_d = tgt;
                    state_d    = REQ;
                end else if (write_ir && valid_q) begin
                    i_d     = ir_buf_q;
                    pc_ir_d = buf_pc_q;
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= REQ;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            buf_pc_q      <= RESET_PC;
            pc_ir_q       <= RESET_PC;
            pend_pc_q     <= RESET_PC;
            i_q           <= '0;
            ir_buf_q      <= '0;
            valid_q       <= 1'b0;
            drop_q        <= 1'b0;
            pend_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            buf_pc_q      <= buf_pc_d;
            pc_ir_q       <= pc_ir_d;
            pend_pc_q     <= pend_pc_d;
            i_q           <= i_d;
            ir_buf_q      <= ir_buf_d;
            valid_q       <= valid_d;
            drop_q        <= drop_d;
            pend_q        <= pend_d;
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect && tgt_misalign) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = tgt_misalign;
    assign misalign_err    = 1'b0;
`endif

    assign I          = i_q;
    assign IR_buf     = ir_buf_q;
    assign W_IR_valid = valid_q;
    assign pc_ir      = pc_ir_q;

    // Response data may only arrive while a request is outstanding.
    assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (state_q == WAIT));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: queued request addresses and instructions are
// compared as the DUT issues requests and loads I.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_pc, write_ir;
    logic [1:0]  pc_s;
    logic [23:0] imm24;
    logic [31:0] reg_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] I, IR_buf, pc_ir;
    logic        W_IR_valid, misalign_err;

    int nchk  = 0;
    int nfail = 0;
    int lat   = 1;
    int cnt   = 0;
    logic [31:0] acc_addr = '0;
    logic [31:0] addr_q[$];
    logic [31:0] inst_q[$];
    logic [31:0] ipc_q[$];

`ifdef IFETCH_ALIGN_CHK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    ifetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_pc     (write_pc),
        .write_ir     (write_ir),
        .pc_s         (pc_s),
        .imm24        (imm24),
        .reg_target   (reg_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .I            (I),
        .IR_buf       (IR_buf),
        .W_IR_valid   (W_IR_valid),
        .pc_ir        (pc_ir),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h0) ? 32'hE3A0_1001 : (32'h5A00_0000 ^ a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard any accepted request, then play the memory model.
    task automatic cyc();
        if (imem_req && imem_ready) begin
            nchk++;
            assert (addr_q.size() > 0) else begin
                nfail++;
                $error("FAIL req_extra: observed request at %h, expected none", imem_addr);
            end
            if (addr_q.size() > 0) chk("req_addr", imem_addr, addr_q.pop_front());
            acc_addr = imem_addr;
            cnt      = lat;
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(acc_addr);
            end
        end
        @(negedge clk);
    endtask

    task automatic accept(input logic [31:0] a);
        addr_q.push_back(a);
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
    endtask

    task automatic expect_inst(input logic [31:0] a);
        inst_q.push_back(word(a));
        ipc_q.push_back(a);
    endtask

    task automatic consume();
        logic [31:0] ei, ep;
        ei = (inst_q.size() > 0) ? inst_q.pop_front() : 32'hDEAD_BEEF;
        ep = (ipc_q.size() > 0) ? ipc_q.pop_front() : 32'hDEAD_BEEF;
        write_ir = 1'b1;
        cyc();
        write_ir = 1'b0;
        chk("I", I, ei);
        chk("pc_ir", pc_ir, ep);
        chk1("valid_after_consume", W_IR_valid, 1'b0);
    endtask

    task automatic redir(input logic [1:0] s, input logic [23:0] imm, input logic [31:0] rt);
        write_pc   = 1'b1;
        pc_s       = s;
        imm24      = imm;
        reg_target = rt;
        cyc();
        write_pc = 1'b0;
        pc_s     = 2'b00;
    endtask

    initial begin
        rst = 1'b1; write_pc = 1'b0; write_ir = 1'b0; pc_s = 2'b00; imm24 = '0;
        reg_target = '0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", W_IR_valid, 1'b0);
        chk("rst_I", I, 32'h0);
        chk("rst_IR_buf", IR_buf, 32'h0);
        chk("rst_pc_ir", pc_ir, 32'h0);
        chk1("rst_misalign", misalign_err, 1'b0);
        rst = 1'b0;
        #1;
        chk1("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);

        // First fetch with 1-cycle memory.
        expect_inst(32'h0);
        accept(32'h0);
        chk1("valid_not_yet", W_IR_valid, 1'b0);
        cyc();
        chk1("valid_n2", W_IR_valid, 1'b1);
        chk("ir_buf_0", IR_buf, 32'hE3A0_1001);
        chk1("full_no_req", imem_req, 1'b0);
        consume();
        chk1("req_after_consume", imem_req, 1'b1);
        chk("addr_4", imem_addr, 32'h4);

        // Stalled handshake keeps request stable.
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk1("stall_req", imem_req, 1'b1);
            chk("stall_addr", imem_addr, 32'h4);
        end
        expect_inst(32'h4);
        accept(32'h4);
        cyc();
        chk1("valid_4", W_IR_valid, 1'b1);
        chk("ir_buf_4", IR_buf, word(32'h4));

        // Buffer full: no requests until consumed.
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk1("full_idle_req", imem_req, 1'b0);
        end
        redir(2'b11, 24'h0, 32'h500);
        chk1("pcs11_valid", W_IR_valid, 1'b1);
        chk1("pcs11_req", imem_req, 1'b0);
        consume();
        chk1("req_next_seq", imem_req, 1'b1);
        chk("addr_8", imem_addr, 32'h8);

        // write_ir with nothing buffered is ignored.
        write_ir = 1'b1;
        cyc();
        write_ir = 1'b0;
        chk("ign_I", I, word(32'h4));
        chk("ign_pc_ir", pc_ir, 32'h4);
        chk("ign_addr", imem_addr, 32'h8);

        // Redirect before acceptance: old request completes, its data dropped.
        redir(2'b10, 24'h0, 32'h100);
        chk1("pend_req", imem_req, 1'b1);
        chk("pend_old_addr", imem_addr, 32'h8);
        accept(32'h8);
        cyc();
        chk1("pend_dropped", W_IR_valid, 1'b0);
        chk1("pend_req_tgt", imem_req, 1'b1);
        chk("pend_addr_tgt", imem_addr, 32'h100);
        expect_inst(32'h100);
        accept(32'h100);
        cyc();
        chk1("valid_100", W_IR_valid, 1'b1);
        consume();
        chk("addr_104", imem_addr, 32'h104);

        // Branch redirect while a slow response is in flight.
        lat = 3;
        accept(32'h104);
        lat = 1;
        redir(2'b01, 24'hFF_FFFE, 32'h0);
        chk1("wait_req", imem_req, 1'b0);
        chk1("wait_valid", W_IR_valid, 1'b0);
        cyc();
        chk1("wait_req2", imem_req, 1'b0);
        cyc();
        chk1("br_dropped", W_IR_valid, 1'b0);
        chk1("br_req", imem_req, 1'b1);
        chk("br_addr", imem_addr, 32'hFC);
        accept(32'hFC);
        cyc();
        chk1("valid_fc", W_IR_valid, 1'b1);
        chk("ir_buf_fc", IR_buf, word(32'hFC));

        // Redirect beats a same-cycle write_ir.
        write_ir = 1'b1;
        redir(2'b10, 24'h0, 32'h200);
        write_ir = 1'b0;
        chk("prio_I", I, word(32'h100));
        chk("prio_pc_ir", pc_ir, 32'h100);
        chk1("prio_valid", W_IR_valid, 1'b0);
        chk1("prio_req", imem_req, 1'b1);
        chk("prio_addr", imem_addr, 32'h200);

        // Misaligned register target.
        accept(32'h200);
        cyc();
        redir(2'b10, 24'h0, 32'h203);
        chk("mis_addr", imem_addr, 32'h200);
        chk1("mis_flag", misalign_err, EXP_MIS);

        // Wrap-around of the sequential fetch address.
        accept(32'h200);
        cyc();
        redir(2'b10, 24'h0, 32'hFFFF_FFFC);
        chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
        expect_inst(32'hFFFF_FFFC);
        accept(32'hFFFF_FFFC);
        cyc();
        chk("ir_buf_wrap", IR_buf, word(32'hFFFF_FFFC));
        consume();
        chk("wrap_addr", imem_addr, 32'h0);
        chk1("mis_held", misalign_err, EXP_MIS);
        chk("addr_q_drained", 32'(addr_q.size()), 32'h0);

        // Asynchronous reset clears everything immediately.
        rst = 1'b1;
        #1;
        chk1("rst2_req", imem_req, 1'b0);
        chk1("rst2_misalign", misalign_err, 1'b0);
        chk("rst2_I", I, 32'h0);
        chk("rst2_pc_ir", pc_ir, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
